// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART.
// TX frames a latched word as start / data (LSB first) / optional parity / stop bits.
// RX synchronises the asynchronous line, rejects short start glitches, samples each
// bit mid-cell and pushes {data, parity_err, frame_err} into a small FIFO with a
// ready/valid pop port and a sticky overrun flag.
module uart_core #(
  parameter int CLK_RATE   = 9_600_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);

  // Bit timing: one bit cell is TU clocks; the first RX sample lands half a cell in.
  localparam int TU   = CLK_RATE / BAUD_RATE;
  localparam int HALF = TU / 2;
  localparam int CW   = $clog2(TU + 1);
  localparam logic [CW-1:0] TU_LAST   = CW'(TU - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Bit-within-state counters cover up to 8 data bits or 2 stop bits.
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  // FIFO geometry: each entry is {data, parity_err, frame_err}.
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_BITS + 2;
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT1_FIFO = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t                 r_tx_state;
  state_t                 w_tx_state_next;
  logic [CW-1:0]          r_tx_cnt;
  logic [3:0]             r_tx_bit;
  logic [DATA_BITS-1:0]   r_tx_shift;
  logic                   r_tx_par;
  logic                   r_prev_start;
  logic                   w_tx_accept;
  logic                   w_tx_bit_end;
  logic                   w_tx_par_calc;

  // Only a rising edge of start seen while idle launches a frame.
  assign w_tx_accept   = (r_tx_state == S_IDLE) && start && !r_prev_start;
  assign w_tx_bit_end  = (r_tx_cnt == TU_LAST);
  // Odd parity inverts the data XOR so the total count of ones is odd.
  assign w_tx_par_calc = (PARITY == 1) ? ~(^tx_data) : (^tx_data);

  // TX state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
    end else begin
      r_tx_state <= w_tx_state_next;
    end
  end

  // TX next-state: every state lasts whole bit cells.
  always_comb begin
    w_tx_state_next = r_tx_state;
    case (r_tx_state)
      S_IDLE: begin
        if (w_tx_accept) w_tx_state_next = S_START;
      end
      S_START: begin
        if (w_tx_bit_end) w_tx_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_tx_bit_end && (r_tx_bit == LAST_DATA))
          w_tx_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_tx_bit_end) w_tx_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_tx_bit_end && (r_tx_bit == LAST_STOP)) w_tx_state_next = S_IDLE;
      end
      default: w_tx_state_next = S_IDLE;
    endcase
  end

  // TX outputs decoded from state so tx falls on the accepting edge.
  always_comb begin
    tx      = 1'b1;
    tx_done = 1'b0;
    case (r_tx_state)
      S_IDLE:   tx_done = 1'b1;
      S_START:  tx      = 1'b0;
      S_DATA:   tx      = r_tx_shift[0];
      S_PARITY: tx      = r_tx_par;
      default:  tx      = 1'b1;
    endcase
  end

  // TX datapath: word/parity latch at acceptance, bit-cell timer, shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_start <= 1'b0;
      r_tx_cnt     <= '0;
      r_tx_bit     <= '0;
      r_tx_shift   <= '0;
      r_tx_par     <= 1'b0;
    end else begin
      r_prev_start <= start;
      if (r_tx_state == S_IDLE) begin
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
        if (w_tx_accept) begin
          r_tx_shift <= tx_data;
          r_tx_par   <= w_tx_par_calc;
        end
      end else if (w_tx_bit_end) begin
        r_tx_cnt <= '0;
        r_tx_bit <= (w_tx_state_next != r_tx_state) ? 4'd0 : (r_tx_bit + 4'd1);
        if (r_tx_state == S_DATA) r_tx_shift <= r_tx_shift >> 1;
      end else begin
        r_tx_cnt <= r_tx_cnt + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  state_t                 r_rx_state;
  state_t                 w_rx_state_next;
  logic                   r_rx_s1;
  logic                   r_rx_s2;
  logic                   r_rx_prev;
  logic [CW-1:0]          r_rx_cnt;
  logic [3:0]             r_rx_bit;
  logic [DATA_BITS-1:0]   r_rx_shift;
  logic                   r_rx_pbit;
  logic                   r_rx_ferr;
  logic                   w_rx_line;
  logic                   w_rx_fall;
  logic                   w_rx_tick;
  logic                   w_rx_push;
  logic                   w_rx_par_calc;
  logic                   w_push_perr;
  logic                   w_push_ferr;
  logic [EW-1:0]          w_push_word;

  assign w_rx_line = r_rx_s2;
  assign w_rx_fall = r_rx_prev && !r_rx_s2;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= S_IDLE;
    end else begin
      r_rx_state <= w_rx_state_next;
    end
  end

  // RX next-state: a start bit that is high at mid-cell is treated as a glitch.
  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      S_IDLE: begin
        if (w_rx_fall) w_rx_state_next = S_START;
      end
      S_START: begin
        if (w_rx_tick) w_rx_state_next = w_rx_line ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_rx_tick && (r_rx_bit == LAST_DATA))
          w_rx_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_rx_tick) w_rx_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_rx_tick && (r_rx_bit == LAST_STOP)) w_rx_state_next = S_IDLE;
      end
      default: w_rx_state_next = S_IDLE;
    endcase
  end

  // RX outputs: sample strobe and the push on the final stop-bit sample.
  always_comb begin
    w_rx_tick = 1'b0;
    case (r_rx_state)
      S_START:                  w_rx_tick = (r_rx_cnt == HALF_LAST);
      S_DATA, S_PARITY, S_STOP: w_rx_tick = (r_rx_cnt == TU_LAST);
      default:                  w_rx_tick = 1'b0;
    endcase
    w_rx_push = (r_rx_state == S_STOP) && w_rx_tick && (r_rx_bit == LAST_STOP);
  end

  // RX datapath: sample timer, LSB-first assembly, parity bit and stop-bit errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_pbit  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else if (r_rx_state == S_IDLE) begin
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_ferr <= 1'b0;
    end else if (w_rx_tick) begin
      r_rx_cnt <= '0;
      r_rx_bit <= (w_rx_state_next != r_rx_state) ? 4'd0 : (r_rx_bit + 4'd1);
      case (r_rx_state)
        S_DATA:   r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
        S_PARITY: r_rx_pbit  <= w_rx_line;
        S_STOP:   r_rx_ferr  <= r_rx_ferr | ~w_rx_line;
        default:  ;
      endcase
    end else begin
      r_rx_cnt <= r_rx_cnt + CNT_ONE;
    end
  end

  // The last stop sample is folded in combinationally so the push needs no extra cycle.
  assign w_rx_par_calc = ^{r_rx_shift, r_rx_pbit};
  assign w_push_perr   = (PARITY == 1) ? ~w_rx_par_calc :
                         (PARITY == 2) ?  w_rx_par_calc : 1'b0;
  assign w_push_ferr   = r_rx_ferr | ~w_rx_line;
  assign w_push_word   = {r_rx_shift, w_push_perr, w_push_ferr};

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0]  r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_overrun;
  logic           w_fifo_full;
  logic           w_pop;
  logic           w_wr;
  logic [EW-1:0]  w_head;

  assign w_fifo_full = (r_count == FIFO_FULL);
  assign rx_valid    = (r_count != '0);
  assign w_pop       = rx_ready && rx_valid;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_wr        = w_rx_push && (!w_fifo_full || w_pop);

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_wr) r_fifo_mem[r_wr_ptr] <= w_push_word;
  end

  // FIFO pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT1_FIFO;
        2'b01:   r_count <= r_count - CNT1_FIFO;
        default: ;
      endcase
      if (w_rx_push && w_fifo_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  // Head outputs read zero while the FIFO is empty.
  assign w_head        = r_fifo_mem[r_rd_ptr];
  assign rx_data       = rx_valid ? w_head[EW-1:2] : '0;
  assign rx_parity_err = rx_valid ? w_head[1] : 1'b0;
  assign rx_frame_err  = rx_valid ? w_head[0] : 1'b0;
  assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core with TU=16: instance A uses 8N1, instance B uses
// 7 data bits, even parity, 2 stop bits. Expected RX words go into a scoreboard
// queue when a frame is sent/driven and are popped when the DUT presents them.
module tb_uart_core;
  localparam int TU = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b;
  logic [7:0] tx_data_a;
  logic [6:0] tx_data_b;
  logic       tx_a, tx_b, tx_done_a, tx_done_b;
  logic       rx_a, rx_b, loop_a, loop_b, rx_drv_a, rx_drv_b;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic       perr_a, perr_b, ferr_a, ferr_b;
  logic       valid_a, valid_b, ready_a, ready_b, ovr_a, ovr_b;

  assign rx_a = loop_a ? tx_a : rx_drv_a;
  assign rx_b = loop_b ? tx_b : rx_drv_b;

  uart_core #(.CLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0),
              .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .tx_data(tx_data_a),
    .tx(tx_a), .tx_done(tx_done_a), .rx(rx_a), .rx_data(rx_data_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .rx_overrun(ovr_a)
  );

  uart_core #(.CLK_RATE(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2),
              .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .tx_data(tx_data_b),
    .tx(tx_b), .tx_done(tx_done_b), .rx(rx_b), .rx_data(rx_data_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .rx_overrun(ovr_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] sb_a[$];
  logic [9:0] sb_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int inst);
    return (inst == 0) ? tx_a : tx_b;
  endfunction
  function automatic logic get_done(input int inst);
    return (inst == 0) ? tx_done_a : tx_done_b;
  endfunction
  function automatic logic get_valid(input int inst);
    return (inst == 0) ? valid_a : valid_b;
  endfunction
  function automatic logic [7:0] get_data(input int inst);
    return (inst == 0) ? rx_data_a : {1'b0, rx_data_b};
  endfunction
  function automatic logic get_perr(input int inst);
    return (inst == 0) ? perr_a : perr_b;
  endfunction
  function automatic logic get_ferr(input int inst);
    return (inst == 0) ? ferr_a : ferr_b;
  endfunction
  function automatic int nbits(input int inst);
    return (inst == 0) ? 10 : 11;
  endfunction

  // Serial frame as line levels, index 0 first on the wire.
  function automatic logic [15:0] build_frame(input int inst, input logic [7:0] d,
                                              input logic flip_par, input logic stop_val);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    if (inst == 0) begin
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      f[9] = stop_val;
    end else begin
      for (int i = 0; i < 7; i++) f[1+i] = d[i];
      f[8]  = (^d[6:0]) ^ flip_par;
      f[9]  = stop_val;
      f[10] = stop_val;
    end
    return f;
  endfunction

  function automatic void sb_push(input int inst, input logic [9:0] w);
    if (inst == 0) sb_a.push_back(w);
    else           sb_b.push_back(w);
  endfunction

  task automatic set_start(input int inst, input logic v, input logic [7:0] d);
    if (inst == 0) begin start_a = v; tx_data_a = d; end
    else begin start_b = v; tx_data_b = d[6:0]; end
  endtask
  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx_drv_a = v; else rx_drv_b = v;
  endtask
  task automatic set_ready(input int inst, input logic v);
    if (inst == 0) ready_a = v; else ready_b = v;
  endtask

  // Send one word through TX; checks every bit cell edge and tx_done timing.
  task automatic send_check(input int inst, input logic [7:0] d, input string tag);
    logic [15:0] f;
    int nb;
    f  = build_frame(inst, d, 1'b0, 1'b1);
    nb = nbits(inst);
    set_start(inst, 1'b1, d);
    @(negedge clk);
    set_start(inst, 1'b0, ~d);
    for (int k = 0; k <= nb * TU; k++) begin
      if (k < nb * TU && ((k % TU) == 0 || (k % TU) == TU - 1))
        chk($sformatf("%s tx bit%0d cyc%0d", tag, k / TU, k % TU), get_tx(inst), f[k/TU]);
      if (k == nb * TU - 1) chk({tag, " tx_done_low"}, get_done(inst), 1'b0);
      if (k == nb * TU)     chk({tag, " tx_done_high"}, get_done(inst), 1'b1);
      if (k < nb * TU) @(negedge clk);
    end
    $display("tx %s: sent %h", tag, d);
    sb_push(inst, {((inst == 0) ? d : {1'b0, d[6:0]}), 2'b00});
  endtask

  // Wait for a head word, compare it with the scoreboard, then pop it.
  task automatic pop_check(input int inst, input string tag);
    logic [9:0] e;
    int t;
    t = 0;
    while (!get_valid(inst) && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " rx_valid"}, get_valid(inst), 1'b1);
    if (get_valid(inst)) begin
      e = 10'h3ff;
      if (inst == 0 && sb_a.size() > 0) e = sb_a.pop_front();
      if (inst == 1 && sb_b.size() > 0) e = sb_b.pop_front();
      chk({tag, " rx_data"}, get_data(inst), e[9:2]);
      chk({tag, " parity_err"}, get_perr(inst), e[1]);
      chk({tag, " frame_err"}, get_ferr(inst), e[0]);
      $display("rx %s: data=%h perr=%b ferr=%b", tag, get_data(inst), get_perr(inst), get_ferr(inst));
      set_ready(inst, 1'b1);
      @(negedge clk);
      set_ready(inst, 1'b0);
    end
  endtask

  // Drive a frame onto rx; optionally pop the head word at cycle pop_at.
  task automatic drive_frame(input int inst, input logic [15:0] f, input int pop_at, input string tag);
    logic [9:0] e;
    for (int c = 0; c < nbits(inst) * TU; c++) begin
      set_rx(inst, f[c/TU]);
      if (c == pop_at) begin
        e = (sb_a.size() > 0) ? sb_a.pop_front() : 10'h3ff;
        chk({tag, " head_before_pop"}, get_data(inst), e[9:2]);
        set_ready(inst, 1'b1);
      end else begin
        set_ready(inst, 1'b0);
      end
      @(negedge clk);
    end
    set_rx(inst, 1'b1);
    set_ready(inst, 1'b0);
    $display("drv %s: frame driven", tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f;
    logic [7:0]  words [5];
    int busy;

    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; tx_data_a = '0; tx_data_b = '0;
    loop_a = 1'b0; loop_b = 1'b0; rx_drv_a = 1'b1; rx_drv_b = 1'b1;
    ready_a = 1'b0; ready_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx_a", tx_a, 1'b1);
    chk("reset tx_done_a", tx_done_a, 1'b1);
    chk("reset rx_valid_a", valid_a, 1'b0);
    chk("reset rx_data_a", rx_data_a, 8'h00);
    chk("reset perr_a", perr_a, 1'b0);
    chk("reset ferr_a", ferr_a, 1'b0);
    chk("reset overrun_a", ovr_a, 1'b0);
    chk("reset tx_b", tx_b, 1'b1);
    chk("reset rx_valid_b", valid_b, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Loopback 8N1.
    loop_a = 1'b1;
    send_check(0, 8'hA5, "loop_a5");
    pop_check(0, "loop_a5");
    chk("loop_a5 empty", valid_a, 1'b0);

    // Even parity, 7 data, 2 stop; then same frame with the parity bit flipped.
    loop_b = 1'b1;
    send_check(1, 8'h5B, "par_5b");
    pop_check(1, "par_5b");
    loop_b = 1'b0;
    f = build_frame(1, 8'h5B, 1'b1, 1'b1);
    drive_frame(1, f, -1, "par_flip");
    sb_push(1, {8'h5B, 1'b1, 1'b0});
    pop_check(1, "par_flip");

    // Start glitch is rejected; a frame with a low stop bit flags frame_err.
    loop_a = 1'b0;
    rx_drv_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch no push", valid_a, 1'b0);
    f = build_frame(0, 8'h3C, 1'b0, 1'b0);
    drive_frame(0, f, -1, "frame_err");
    repeat (TU) @(negedge clk);
    sb_push(0, {8'h3C, 1'b0, 1'b1});
    pop_check(0, "frame_err");

    // Overrun: five back-to-back words with no pops; the fifth is dropped.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
    for (int w = 0; w < 5; w++) begin
      f = build_frame(0, words[w], 1'b0, 1'b1);
      drive_frame(0, f, -1, "ovr");
      if (w < 4) sb_push(0, {words[w], 2'b00});
    end
    repeat (8) @(negedge clk);
    chk("overrun set", ovr_a, 1'b1);
    for (int w = 0; w < 4; w++) pop_check(0, "ovr");
    chk("ovr fifth dropped", valid_a, 1'b0);

    do_reset();
    @(negedge clk);
    chk("overrun cleared by reset", ovr_a, 1'b0);

    // Full FIFO: pop and push land in the same cycle, nothing is lost.
    words[0] = 8'h66; words[1] = 8'h77; words[2] = 8'h88; words[3] = 8'h99; words[4] = 8'hAA;
    for (int w = 0; w < 4; w++) begin
      f = build_frame(0, words[w], 1'b0, 1'b1);
      drive_frame(0, f, -1, "fill");
      sb_push(0, {words[w], 2'b00});
    end
    f = build_frame(0, words[4], 1'b0, 1'b1);
    drive_frame(0, f, 154, "simul");
    sb_push(0, {words[4], 2'b00});
    repeat (8) @(negedge clk);
    chk("simul no overrun", ovr_a, 1'b0);
    for (int w = 0; w < 4; w++) pop_check(0, "simul");
    chk("simul drained", valid_a, 1'b0);

    // Reset during bit 3 of a loopback frame aborts both directions.
    loop_a = 1'b1;
    set_start(0, 1'b1, 8'h5A);
    @(negedge clk);
    set_start(0, 1'b0, 8'h5A);
    repeat (72) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset tx", tx_a, 1'b1);
    chk("midreset tx_done", tx_done_a, 1'b1);
    chk("midreset rx_valid", valid_a, 1'b0);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("midreset no partial push", valid_a, 1'b0);
    send_check(0, 8'h3A, "after_reset");
    pop_check(0, "after_reset");

    // start held high through reset sends exactly one frame.
    set_start(0, 1'b1, 8'hC3);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    busy = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!tx_done_a) busy++;
    end
    set_start(0, 1'b0, 8'hC3);
    chk("held start busy cycles", busy, 160);
    sb_push(0, {8'hC3, 2'b00});
    pop_check(0, "held_start");
    repeat (20) @(negedge clk);
    chk("held start single word", valid_a, 1'b0);

    // start edges while busy are ignored.
    set_start(0, 1'b1, 8'h96);
    @(negedge clk);
    set_start(0, 1'b0, 8'h96);
    busy = 0;
    for (int c = 0; c < 300; c++) begin
      if (c >= 20 && c < 120) set_start(0, (c % 8) < 4, 8'($urandom));
      else                    set_start(0, 1'b0, 8'h96);
      if (!tx_done_a) busy++;
      @(negedge clk);
    end
    chk("busy edges ignored cycles", busy, 160);
    sb_push(0, {8'h96, 2'b00});
    pop_check(0, "busy_edges");
    repeat (20) @(negedge clk);
    chk("busy edges single word", valid_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
